// File: rtl/bus_arbiter.sv
// Two-master, single-slave bus arbiter.
// Round-robin between master 0 (CPU) and master 1, with a per-transfer timeout.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; slave bus driven to zero; arbitration happens here
//   GNT0  | master 0 owns the slave bus until done, timeout or abort
//   GNT1  | master 1 owns the slave bus until done, timeout or abort
//
// Every output is decoded from registered state plus the granted master's
// live fields. Because of that, grant_o has no combinational path from the
// request inputs, and pulling reset low clears the outputs at once.
module bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [2:0]  m0_byteNr_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_done_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [2:0]  m1_byteNr_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_done_o,
  output logic        m1_err_o,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [2:0]  s_byteNr_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_done_i,

  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;   // last winner: 0 = master 0, 1 = master 1
  logic [7:0]  cnt_q, cnt_d;

  logic        granted;
  logic        cur_req;
  logic        tout_hit;

  // Request of whichever master currently owns the bus, and the timeout condition.
  // A dropped request counts as an abort, not a timeout, so it never raises err.
  always_comb begin
    granted  = (state_q != IDLE);
    cur_req  = 1'b0;
    if (state_q == GNT0) cur_req = m0_req_i;
    if (state_q == GNT1) cur_req = m1_req_i;
    tout_hit = granted && (TIMEOUT != 8'd0) && (cnt_q == (TIMEOUT - 8'd1))
               && !s_done_i && cur_req;
  end

  // State, last winner and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold ownership until the transfer ends.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (m0_req_i && m1_req_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_req_i) begin
          state_d = GNT0;
        end else if (m1_req_i) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (s_done_i || tout_hit || !cur_req) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Slave-side request mux: the owner's fields, or all zeros when idle.
  // On a timeout cycle the request is withdrawn from the slave.
  always_comb begin
    grant_o    = {state_q == GNT1, state_q == GNT0};
    s_req_o    = cur_req && !tout_hit;
    s_we_o     = 1'b0;
    s_adr_o    = 32'h0;
    s_dat_o    = 32'h0;
    s_byteNr_o = 3'd0;
    if (state_q == GNT0) begin
      s_we_o     = m0_we_i;
      s_adr_o    = m0_adr_i;
      s_dat_o    = m0_dat_i;
      s_byteNr_o = m0_byteNr_i;
    end else if (state_q == GNT1) begin
      s_we_o     = m1_we_i;
      s_adr_o    = m1_adr_i;
      s_dat_o    = m1_dat_i;
      s_byteNr_o = m1_byteNr_i;
    end
  end

  // Master-side returns: read data, done and error go only to the owner.
  // A slave done arriving in the timeout cycle wins, so err stays low then.
  always_comb begin
    m0_dat_o  = grant_o[0] ? s_dat_i : 32'h0;
    m1_dat_o  = grant_o[1] ? s_dat_i : 32'h0;
    m0_done_o = grant_o[0] && (s_done_i || tout_hit);
    m1_done_o = grant_o[1] && (s_done_i || tout_hit);
    m0_err_o  = grant_o[0] && tout_hit;
    m1_err_o  = grant_o[1] && tout_hit;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Main instance uses TIMEOUT=4; a second
// instance on the same inputs uses TIMEOUT=0 to confirm the timeout disable.
module tb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, s_done_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic [2:0]  m0_byteNr_i, m1_byteNr_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_done_o, m0_err_o, m1_done_o, m1_err_o, s_req_o, s_we_o;
  logic [2:0]  s_byteNr_o;
  logic [1:0]  grant_o;

  logic [31:0] nt_m0_dat_o, nt_m1_dat_o, nt_s_adr_o, nt_s_dat_o;
  logic        nt_m0_done_o, nt_m0_err_o, nt_m1_done_o, nt_m1_err_o, nt_s_req_o, nt_s_we_o;
  logic [2:0]  nt_s_byteNr_o;
  logic [1:0]  nt_grant_o;

  int checks = 0;
  int errors = 0;

  // {grant[1:0], s_req, m0_done, m0_err, m1_done, m1_err}
  wire [6:0] st = {grant_o, s_req_o, m0_done_o, m0_err_o, m1_done_o, m1_err_o};

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_byteNr_i(m0_byteNr_i), .m0_dat_o(m0_dat_o), .m0_done_o(m0_done_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_byteNr_i(m1_byteNr_i), .m1_dat_o(m1_dat_o), .m1_done_o(m1_done_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_byteNr_o(s_byteNr_o), .s_dat_i(s_dat_i), .s_done_i(s_done_i), .grant_o(grant_o)
  );

  bus_arbiter #(.TIMEOUT(8'd0)) dut_nt (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_byteNr_i(m0_byteNr_i), .m0_dat_o(nt_m0_dat_o), .m0_done_o(nt_m0_done_o), .m0_err_o(nt_m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_byteNr_i(m1_byteNr_i), .m1_dat_o(nt_m1_dat_o), .m1_done_o(nt_m1_done_o), .m1_err_o(nt_m1_err_o),
    .s_req_o(nt_s_req_o), .s_we_o(nt_s_we_o), .s_adr_o(nt_s_adr_o), .s_dat_o(nt_s_dat_o),
    .s_byteNr_o(nt_s_byteNr_o), .s_dat_i(s_dat_i), .s_done_i(s_done_i), .grant_o(nt_grant_o)
  );

  task automatic nxt;
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid;
    @(negedge clk_i);
  endtask

  task automatic clear_inputs;
    m0_req_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_byteNr_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_byteNr_i = 0;
    s_done_i = 0; s_dat_i = 0;
  endtask

  task automatic do_reset;
    rst_i = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_i = 1'b0;
    m0_req_i = 1; s_dat_i = 32'hFFFF_FFFF; s_done_i = 1;
    #3;
    checks++;
    if (st !== 7'b0000000 || m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0 || s_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs st=%b m0_dat=%h s_adr=%h exp st=0000000 zeros", st, m0_dat_o, s_adr_o);
    end
    nxt();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_hold st=%b exp=0000000", st);
    end
  endtask

  task automatic test_single;
    do_reset();
    m0_req_i = 1; m0_adr_i = 32'h100; m0_byteNr_i = 3'd4; m0_we_i = 0;
    mid();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL single_latency st=%b exp=0000000", st);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b0110000 || s_adr_o !== 32'h100 || s_byteNr_o !== 3'd4) begin
      errors++;
      $display("FAIL single_grant st=%b adr=%h bn=%0d exp st=0110000 adr=100 bn=4", st, s_adr_o, s_byteNr_o);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b0110000) begin
      errors++;
      $display("FAIL single_wait st=%b exp=0110000", st);
    end
    nxt();
    s_done_i = 1; s_dat_i = 32'hDEADBEEF;
    mid();
    checks++;
    if (st !== 7'b0111000 || m0_dat_o !== 32'hDEADBEEF || m1_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL single_done st=%b m0_dat=%h m1_dat=%h exp st=0111000 deadbeef 0", st, m0_dat_o, m1_dat_o);
    end
    nxt();
    s_done_i = 0; m0_req_i = 0;
    mid();
    checks++;
    if (st !== 7'b0000000 || m0_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL single_idle st=%b m0_dat=%h exp st=0000000 dat=0", st, m0_dat_o);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    m0_req_i = 1; m0_adr_i = 32'hA0; m0_we_i = 0; m0_byteNr_i = 3'd1; m0_dat_i = 32'h11;
    m1_req_i = 1; m1_adr_i = 32'hB0; m1_we_i = 1; m1_byteNr_i = 3'd2; m1_dat_i = 32'h22;
    nxt();
    s_done_i = 1;
    mid();
    checks++;
    if (st !== 7'b0111000 || s_adr_o !== 32'hA0 || s_we_o !== 1'b0) begin
      errors++;
      $display("FAIL rr_first st=%b adr=%h we=%b exp st=0111000 adr=a0 we=0", st, s_adr_o, s_we_o);
    end
    nxt();
    s_done_i = 0;
    mid();
    checks++;
    if (st !== 7'b0000000 || s_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL rr_idle1 st=%b adr=%h exp st=0000000 adr=0", st, s_adr_o);
    end
    nxt();
    s_done_i = 1;
    mid();
    checks++;
    if (st !== 7'b1010010 || {s_we_o, s_adr_o, s_dat_o, s_byteNr_o} !== {1'b1, 32'hB0, 32'h22, 3'd2}) begin
      errors++;
      $display("FAIL rr_second st=%b we=%b adr=%h dat=%h bn=%0d exp st=1010010 1 b0 22 2",
               st, s_we_o, s_adr_o, s_dat_o, s_byteNr_o);
    end
    nxt();
    s_done_i = 0;
    mid();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL rr_idle2 st=%b exp=0000000", st);
    end
    nxt();
    s_done_i = 1;
    mid();
    checks++;
    if (st !== 7'b0111000) begin
      errors++;
      $display("FAIL rr_third st=%b exp=0111000", st);
    end
    nxt();
    s_done_i = 0; m0_req_i = 0; m1_req_i = 0;
  endtask

  task automatic test_no_preempt;
    do_reset();
    m1_req_i = 1;
    nxt();
    m0_req_i = 1;
    mid();
    checks++;
    if (st !== 7'b1010000) begin
      errors++;
      $display("FAIL np_grant1 st=%b exp=1010000", st);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b1010000) begin
      errors++;
      $display("FAIL np_hold st=%b exp=1010000", st);
    end
    nxt();
    s_done_i = 1;
    mid();
    checks++;
    if (st !== 7'b1010010) begin
      errors++;
      $display("FAIL np_done1 st=%b exp=1010010", st);
    end
    nxt();
    s_done_i = 0; m1_req_i = 0;
    mid();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL np_idle st=%b exp=0000000", st);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b0110000) begin
      errors++;
      $display("FAIL np_grant0 st=%b exp=0110000", st);
    end
    nxt();
    s_done_i = 1;
    nxt();
    s_done_i = 0; m0_req_i = 0;
  endtask

  task automatic test_timeout;
    do_reset();
    m0_req_i = 1;
    for (int i = 1; i <= 3; i++) begin
      nxt(); mid();
      checks++;
      if (st !== 7'b0110000) begin
        errors++;
        $display("FAIL tmo_busy cycle=%0d st=%b exp=0110000", i, st);
      end
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b0101100) begin
      errors++;
      $display("FAIL tmo_fire st=%b exp=0101100", st);
    end
    checks++;
    if ({nt_s_req_o, nt_m0_done_o, nt_m0_err_o} !== 3'b100) begin
      errors++;
      $display("FAIL tmo_disabled got req/done/err=%b exp=100", {nt_s_req_o, nt_m0_done_o, nt_m0_err_o});
    end
    nxt();
    m0_req_i = 0;
    mid();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL tmo_idle st=%b exp=0000000", st);
    end

    do_reset();
    m0_req_i = 1;
    repeat (3) nxt();
    nxt();
    s_done_i = 1;
    mid();
    checks++;
    if (st !== 7'b0111000) begin
      errors++;
      $display("FAIL tmo_done_prio st=%b exp=0111000", st);
    end
    nxt();
    s_done_i = 0; m0_req_i = 0;
  endtask

  task automatic test_idle_done;
    do_reset();
    s_done_i = 1; s_dat_i = 32'h5555_AAAA;
    mid();
    checks++;
    if (st !== 7'b0000000 || m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL idle_done st=%b m0_dat=%h m1_dat=%h exp st=0000000 zeros", st, m0_dat_o, m1_dat_o);
    end
    s_done_i = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    m0_req_i = 1;
    nxt();
    nxt();
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL rstmid_async st=%b exp=0000000", st);
    end
    nxt();
    rst_i = 1'b1;
    mid();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL rstmid_release st=%b exp=0000000", st);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b0110000) begin
      errors++;
      $display("FAIL rstmid_regrant st=%b exp=0110000", st);
    end
    nxt();
    s_done_i = 1;
    nxt();
    s_done_i = 0; m0_req_i = 0;
  endtask

  task automatic test_abort;
    do_reset();
    m0_req_i = 1; m1_req_i = 1;
    nxt(); mid();
    checks++;
    if (st !== 7'b0110000) begin
      errors++;
      $display("FAIL abort_grant st=%b exp=0110000", st);
    end
    nxt();
    m0_req_i = 0;
    mid();
    checks++;
    if (st !== 7'b0100000) begin
      errors++;
      $display("FAIL abort_drop st=%b exp=0100000", st);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL abort_idle st=%b exp=0000000", st);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b1010000) begin
      errors++;
      $display("FAIL abort_m1 st=%b exp=1010000", st);
    end
    nxt();
    s_done_i = 1;
    nxt();
    s_done_i = 0; m1_req_i = 0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    m0_req_i = 1; m0_adr_i = 32'h200;
    nxt();
    s_done_i = 1; s_dat_i = 32'h1234_5678;
    mid();
    checks++;
    if (st !== 7'b0111000 || m0_dat_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_fetch st=%b dat=%h exp st=0111000 dat=12345678", st, m0_dat_o);
    end
    nxt();
    s_done_i = 0; m0_adr_i = 32'h300; m0_we_i = 1;
    mid();
    checks++;
    if (st !== 7'b0000000) begin
      errors++;
      $display("FAIL b2b_idle st=%b exp=0000000", st);
    end
    nxt(); mid();
    checks++;
    if (st !== 7'b0110000 || s_adr_o !== 32'h300 || s_we_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load st=%b adr=%h we=%b exp st=0110000 adr=300 we=1", st, s_adr_o, s_we_o);
    end
    nxt();
    s_done_i = 1;
    nxt();
    s_done_i = 0; m0_req_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_idle_done();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
